// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for the counter tile: captures data_in on an accepted
// send and shifts it out LSB first, with registered tx/busy/done.
module count_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    state_t            w_state;
    logic [BAUD_W-1:0] w_baud;
    logic [2:0]        w_bit;
    logic [7:0]        w_shift;
    logic              w_tx;
    logic              w_busy;
    logic              w_done;
    logic              w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);

    // State and output registers; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Next state plus next output values, so outputs line up with the state.
    always_comb begin
        w_state = r_state;
        w_baud  = r_baud;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_done  = 1'b0;

        case (r_state)
            IDLE: begin
                if (send) begin
                    w_state = START;
                    w_shift = data_in;
                    w_baud  = '0;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            START: begin
                w_busy = 1'b1;
                w_tx   = 1'b0;
                if (w_bit_end) begin
                    w_state = DATA;
                    w_baud  = '0;
                    w_bit   = '0;
                    w_tx    = r_shift[0];
                end else begin
                    w_baud = r_baud + BAUD_W'(1);
                end
            end
            DATA: begin
                w_busy = 1'b1;
                w_tx   = r_shift[0];
                if (w_bit_end) begin
                    w_baud  = '0;
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state = STOP;
                        w_bit   = '0;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit = r_bit + 3'd1;
                        w_tx  = r_shift[1];
                    end
                end else begin
                    w_baud = r_baud + BAUD_W'(1);
                end
            end
            STOP: begin
                w_busy = 1'b1;
                if (w_bit_end) begin
                    w_state = IDLE;
                    w_baud  = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_baud = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
